// File: rtl/decoder_node_clk.sv
// Clocked address-decode node for the NoC binary routing tree: captures one packet,
// announces its route on the select channel, then forwards it on Out0 or Out1.
module decoder_node_clk #(
   parameter int                   W         = 9,
   parameter int                   ADDR_LSB  = 5,
   parameter int                   ADDR_BITS = 4,
   parameter logic [ADDR_BITS-1:0] NODE_ADDR = 4'b1100,
   parameter logic [ADDR_BITS-1:0] NODE_MASK = 4'b1100,
   parameter bit                   LEAF      = 1'b1,
   parameter int                   CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [W-1:0]     in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             s_data,
   output logic             s_valid,
   input  logic             s_ready,
   output logic [W-1:0]     out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [W-1:0]     out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic             busy
);

   function automatic int lead_ones(input logic [ADDR_BITS-1:0] m);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      for (int i = ADDR_BITS - 1; i >= 0; i--) begin
         if (!done && m[i]) n++;
         else               done = 1'b1;
      end
      return n;
   endfunction

   function automatic int count_ones(input logic [ADDR_BITS-1:0] m);
      int n;
      n = 0;
      for (int i = 0; i < ADDR_BITS; i++) n += int'(m[i]);
      return n;
   endfunction

   localparam int K        = lead_ones(NODE_MASK);
   localparam int TEST_BIT = (K < ADDR_BITS) ? (ADDR_BITS - 1 - K) : 0;

   generate
      if ((ADDR_LSB + ADDR_BITS > W) || (count_ones(NODE_MASK) != K)) begin : g_bad_param
         $error("decoder_node_clk: address field exceeds packet or NODE_MASK not prefix form");
      end
   endgenerate

   // Leaf: masked equality picks Out0; branch: first bit below the mask prefix picks the port.
   function automatic logic route_of(input logic [ADDR_BITS-1:0] a);
      if (LEAF)                return ((a & NODE_MASK) == NODE_ADDR) ? 1'b0 : 1'b1;
      else if (K < ADDR_BITS)  return a[TEST_BIT];
      else                     return 1'b1;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   typedef enum logic [1:0] {ST_IDLE, ST_SEL, ST_DATA} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [W-1:0]          r_hold;
   logic                  r_route;
   logic [CNT_W-1:0]      r_cnt0;
   logic [CNT_W-1:0]      r_cnt1;
   logic                  w_capture;
   logic                  w_del0;
   logic                  w_del1;
   logic [ADDR_BITS-1:0]  w_addr;

   assign w_addr = in_data[ADDR_LSB +: ADDR_BITS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      in_ready   = 1'b0;
      s_valid    = 1'b0;
      out0_valid = 1'b0;
      out1_valid = 1'b0;
      w_capture  = 1'b0;
      w_del0     = 1'b0;
      w_del1     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_capture = 1'b1;
               w_next    = ST_SEL;
            end
         end
         ST_SEL: begin
            s_valid = 1'b1;
            if (s_ready) w_next = ST_DATA;
         end
         ST_DATA: begin
            if (!r_route) begin
               out0_valid = 1'b1;
               w_del0     = out0_ready;
            end else begin
               out1_valid = 1'b1;
               w_del1     = out1_ready;
            end
            if (w_del0 || w_del1) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold  <= '0;
         r_route <= 1'b0;
      end else if (w_capture) begin
         r_hold  <= in_data;
         r_route <= route_of(w_addr);
      end
   end

   // Clear takes priority over a coincident delivery.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (stat_clr) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_del0) r_cnt0 <= sat_inc(r_cnt0);
         if (w_del1) r_cnt1 <= sat_inc(r_cnt1);
      end
   end

   assign s_data    = r_route;
   assign out0_data = r_hold;
   assign out1_data = r_hold;
   assign cnt0      = r_cnt0;
   assign cnt1      = r_cnt1;
   assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_decoder_node_clk.sv
// Directed bench for decoder_node_clk: four instances (leaf, branch, full-mask branch,
// 2-bit counters) share one stimulus stream; each check compares against hand-derived values.
module tb_decoder_node_clk;

   logic       clk = 1'b0;
   logic       reset;
   logic [8:0] in_data;
   logic       in_valid, s_ready, out0_ready, out1_ready, stat_clr;

   logic [3:0] in_ready_w, s_data_w, s_valid_w, o0v, o1v, busy_w;
   logic [8:0] o0d [4];
   logic [8:0] o1d [4];
   logic [15:0] c0 [3];
   logic [15:0] c1 [3];
   logic [1:0] c0_u3, c1_u3;

   logic [3:0] cap_sd, cap_sv, cap_ir, cap_o0v, cap_o1v;
   logic [8:0] cap_o0d [4];
   logic [8:0] cap_o1d [4];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   decoder_node_clk u0 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_w[0]),
      .s_data(s_data_w[0]), .s_valid(s_valid_w[0]), .s_ready(s_ready),
      .out0_data(o0d[0]), .out0_valid(o0v[0]), .out0_ready(out0_ready),
      .out1_data(o1d[0]), .out1_valid(o1v[0]), .out1_ready(out1_ready),
      .stat_clr(stat_clr), .cnt0(c0[0]), .cnt1(c1[0]), .busy(busy_w[0]));

   decoder_node_clk #(.LEAF(1'b0)) u1 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_w[1]),
      .s_data(s_data_w[1]), .s_valid(s_valid_w[1]), .s_ready(s_ready),
      .out0_data(o0d[1]), .out0_valid(o0v[1]), .out0_ready(out0_ready),
      .out1_data(o1d[1]), .out1_valid(o1v[1]), .out1_ready(out1_ready),
      .stat_clr(stat_clr), .cnt0(c0[1]), .cnt1(c1[1]), .busy(busy_w[1]));

   decoder_node_clk #(.LEAF(1'b0), .NODE_MASK(4'b1111)) u2 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_w[2]),
      .s_data(s_data_w[2]), .s_valid(s_valid_w[2]), .s_ready(s_ready),
      .out0_data(o0d[2]), .out0_valid(o0v[2]), .out0_ready(out0_ready),
      .out1_data(o1d[2]), .out1_valid(o1v[2]), .out1_ready(out1_ready),
      .stat_clr(stat_clr), .cnt0(c0[2]), .cnt1(c1[2]), .busy(busy_w[2]));

   decoder_node_clk #(.CNT_W(2)) u3 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_w[3]),
      .s_data(s_data_w[3]), .s_valid(s_valid_w[3]), .s_ready(s_ready),
      .out0_data(o0d[3]), .out0_valid(o0v[3]), .out0_ready(out0_ready),
      .out1_data(o1d[3]), .out1_valid(o1v[3]), .out1_ready(out1_ready),
      .stat_clr(stat_clr), .cnt0(c0_u3), .cnt1(c1_u3), .busy(busy_w[3]));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   // One packet with all readies high: capture, select, deliver on consecutive edges.
   task automatic xfer(input logic [8:0] d, input logic clr);
      in_data = d; in_valid = 1'b1;
      s_ready = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
      @(posedge clk); #1;
      cap_sd = s_data_w; cap_sv = s_valid_w; cap_ir = in_ready_w;
      in_valid = 1'b0;
      @(posedge clk); #1;
      cap_o0v = o0v; cap_o1v = o1v;
      for (int i = 0; i < 4; i++) begin
         cap_o0d[i] = o0d[i];
         cap_o1d[i] = o1d[i];
      end
      stat_clr = clr;
      @(posedge clk); #1;
      stat_clr = 1'b0;
   endtask

   initial begin
      int seen;
      reset = 1'b1; in_data = '0; in_valid = 1'b0; s_ready = 1'b0;
      out0_ready = 1'b0; out1_ready = 1'b0; stat_clr = 1'b0;
      #22 reset = 1'b0;
      #1;

      check_val("rst_in_ready", 32'(in_ready_w[0]), 1);
      check_val("rst_s_valid", 32'(s_valid_w[0]), 0);
      check_val("rst_s_data", 32'(s_data_w[0]), 0);
      check_val("rst_out_valids", 32'({o0v[0], o1v[0]}), 0);
      check_val("rst_out0_data", 32'(o0d[0]), 0);
      check_val("rst_cnts", 32'({c0[0], c1[0]}), 0);
      check_val("rst_busy", 32'(busy_w[0]), 0);

      // T1 leaf hit
      xfer(9'h190, 1'b0);
      check_val("t1_s_valid", 32'(cap_sv[0]), 1);
      check_val("t1_s_data", 32'(cap_sd[0]), 0);
      check_val("t1_in_ready_sel", 32'(cap_ir[0]), 0);
      check_val("t1_out0_valid", 32'(cap_o0v[0]), 1);
      check_val("t1_out1_valid", 32'(cap_o1v[0]), 0);
      check_val("t1_out0_data", 32'(cap_o0d[0]), 32'h190);
      check_val("t1_cnt0", 32'(c0[0]), 1);
      check_val("t1_cnt1", 32'(c1[0]), 0);
      check_val("t1_in_ready_after", 32'(in_ready_w[0]), 1);
      check_val("t1_branch_s", 32'(cap_sd[1]), 0);
      check_val("t1_fullmask_s", 32'(cap_sd[2]), 1);

      // T2 leaf miss
      xfer(9'h0A0, 1'b0);
      check_val("t2_s_data", 32'(cap_sd[0]), 1);
      check_val("t2_out1_valid", 32'(cap_o1v[0]), 1);
      check_val("t2_out0_valid", 32'(cap_o0v[0]), 0);
      check_val("t2_out1_data", 32'(cap_o1d[0]), 32'h0A0);
      check_val("t2_cnt1", 32'(c1[0]), 1);
      check_val("t2_cnt0", 32'(c0[0]), 1);

      // T3 branch prefix test on bit 6, and full mask always Out1
      xfer(9'h180, 1'b0);
      check_val("t3_br180_s", 32'(cap_sd[1]), 0);
      check_val("t3_br180_out0", 32'(cap_o0d[1]), 32'h180);
      check_val("t3_fm180_s", 32'(cap_sd[2]), 1);
      xfer(9'h1C0, 1'b0);
      check_val("t3_br1C0_s", 32'(cap_sd[1]), 1);
      check_val("t3_br1C0_out1v", 32'(cap_o1v[1]), 1);
      check_val("t3_br1C0_out1", 32'(cap_o1d[1]), 32'h1C0);
      check_val("t3_br_cnt0", 32'(c0[1]), 3);
      check_val("t3_br_cnt1", 32'(c1[1]), 1);
      check_val("t3_fm_cnt1", 32'(c1[2]), 4);
      check_val("t3_fm_cnt0", 32'(c0[2]), 0);

      // T4 backpressure on select then on Out0
      apply_reset();
      in_data = 9'h190; in_valid = 1'b1; s_ready = 1'b0; out0_ready = 1'b0; out1_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_val("t4_s_held", 32'({s_valid_w[0], s_data_w[0], in_ready_w[0]}), 32'b100);
         if (i < 4) begin @(posedge clk); #1; end
      end
      s_ready = 1'b1;
      @(posedge clk); #1;
      s_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_val("t4_out0_held", 32'({o0v[0], s_valid_w[0], in_ready_w[0]}), 32'b100);
         check_val("t4_out0_data", 32'(o0d[0]), 32'h190);
         check_val("t4_cnt0_wait", 32'(c0[0]), 0);
         @(posedge clk); #1;
      end
      out0_ready = 1'b1;
      @(posedge clk); #1;
      check_val("t4_cnt0_done", 32'(c0[0]), 1);
      check_val("t4_idle", 32'({in_ready_w[0], o0v[0]}), 32'b10);
      @(posedge clk); #1;
      check_val("t4_single_delivery", 32'(c0[0]), 1);

      // T5 saturation with 2-bit counters, then clear on a delivery cycle
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         xfer(9'h190, 1'b0);
         check_val("t5_sat_cnt0", 32'(c0_u3), (i < 3) ? 32'(i + 1) : 32'd3);
      end
      xfer(9'h190, 1'b1);
      check_val("t5_clr_wins", 32'(c0_u3), 0);
      check_val("t5_clr_wins_wide", 32'(c0[0]), 0);

      // T6 reset while holding in DATA
      apply_reset();
      xfer(9'h190, 1'b0);
      in_data = 9'h190; in_valid = 1'b1; s_ready = 1'b1; out0_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check_val("t6_in_data_state", 32'(o0v[0]), 1);
      reset = 1'b1;
      #1;
      check_val("t6_async_drop", 32'({o0v[0], o1v[0], s_valid_w[0], busy_w[0]}), 0);
      check_val("t6_async_data", 32'(o0d[0]), 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check_val("t6_in_ready", 32'(in_ready_w[0]), 1);
      check_val("t6_cnts", 32'({c0[0], c1[0]}), 0);
      out0_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (o0v[0] || o1v[0] || s_valid_w[0]) seen++;
         @(posedge clk); #1;
      end
      check_val("t6_no_stale", 32'(seen), 0);
      check_val("t6_cnt0_after", 32'(c0[0]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
